// File: rtl/forward_transform_tile_engine.sv
// Forward 4x4 transform tile engine.
// Walks a FRAME_W x FRAME_H frame in raster-ordered 4x4 tiles, fetches each tile from a
// 1-cycle-latency pixel store, applies T = M*X*M^T (M = integer DCT or Hadamard) and streams
// the 16 coefficients of each tile over a valid/ready port.
module forward_transform_tile_engine #(
  parameter int unsigned PIX_W   = 9,
  parameter int unsigned FRAME_W = 8,
  parameter int unsigned FRAME_H = 8,
  localparam int unsigned ADDR_W = $clog2(FRAME_W * FRAME_H),
  localparam int unsigned COEF_W = PIX_W + 7,
  localparam int unsigned NT     = (FRAME_W / 4) * (FRAME_H / 4),
  localparam int unsigned TILE_W = (NT > 1) ? $clog2(NT) : 1
) (
  input  logic              in_clk,
  input  logic              in_rst_n,
  input  logic              in_start,
  input  logic              in_mode,
  input  logic              in_abort,
  output logic [ADDR_W-1:0] out_mem_addr,
  input  logic [PIX_W-1:0]  in_mem_data,
  output logic [COEF_W-1:0] out_coef,
  output logic              out_coef_valid,
  input  logic              in_coef_ready,
  output logic [3:0]        out_coef_idx,
  output logic [TILE_W-1:0] out_tile_idx,
  output logic              out_busy,
  output logic              out_done
);

  localparam int unsigned TILES_X = FRAME_W / 4;
  localparam int unsigned TILES_Y = FRAME_H / 4;
  localparam int unsigned TX_W    = (TILES_X > 1) ? $clog2(TILES_X) : 1;
  localparam int unsigned TY_W    = (TILES_Y > 1) ? $clog2(TILES_Y) : 1;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StLoad = 3'd1;
  localparam logic [2:0] StLast = 3'd2;
  localparam logic [2:0] StRow  = 3'd3;
  localparam logic [2:0] StCol  = 3'd4;
  localparam logic [2:0] StEmit = 3'd5;
  localparam logic [2:0] StDone = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        idx_q, idx_d;
  logic [TILE_W-1:0] tile_q, tile_d;
  logic [TX_W-1:0]   tx_q, tx_d;
  logic [TY_W-1:0]   ty_q, ty_d;
  logic              mode_q, mode_d;
  // Tracks which X entry the pixel arriving this cycle belongs to (read latency of 1).
  logic              cap_vld_q, cap_vld_d;
  logic [3:0]        cap_idx_q, cap_idx_d;

  logic [PIX_W-1:0]         x_q [16];
  logic [PIX_W-1:0]         x_d [16];
  logic signed [COEF_W-1:0] y_q [16];
  logic signed [COEF_W-1:0] y_d [16];
  logic signed [COEF_W-1:0] t_q [16];
  logic signed [COEF_W-1:0] t_d [16];
  logic signed [COEF_W-1:0] y_calc [16];
  logic signed [COEF_W-1:0] t_calc [16];

  logic [ADDR_W-1:0] row_a, col_a, addr_calc;

  // Row i of the selected matrix as four 3-bit two's-complement weights, column 0 in the MSBs.
  function automatic logic [11:0] row_weights(input logic mode, input logic [1:0] i);
    logic [11:0] row;
    case ({mode, i})
      3'b000, 3'b100: row = 12'b001_001_001_001;
      3'b001:         row = 12'b010_001_111_110;
      3'b010, 3'b110: row = 12'b001_111_111_001;
      3'b011:         row = 12'b001_110_010_111;
      3'b101:         row = 12'b001_001_111_111;
      3'b111:         row = 12'b001_111_001_111;
      default:        row = '0;
    endcase
    return row;
  endfunction

  // M[i][k] * v using only negate and shift, since weights are in {-2,-1,1,2}.
  function automatic logic signed [COEF_W-1:0] scale(input logic mode, input logic [1:0] i,
                                                     input logic [1:0] k,
                                                     input logic signed [COEF_W-1:0] v);
    logic [11:0] row;
    logic [2:0]  w;
    logic signed [COEF_W-1:0] res;
    row = row_weights(mode, i);
    case (k)
      2'd0:    w = row[11:9];
      2'd1:    w = row[8:6];
      2'd2:    w = row[5:3];
      default: w = row[2:0];
    endcase
    case (w)
      3'b001:  res = v;
      3'b111:  res = -v;
      3'b010:  res = v <<< 1;
      3'b110:  res = -(v <<< 1);
      default: res = '0;
    endcase
    return res;
  endfunction

  // Row pass: Y = X * M^T.
  always_comb begin
    logic signed [COEF_W-1:0] acc;
    y_calc = '{default: '0};
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 4; j++) begin
        acc = '0;
        for (int c = 0; c < 4; c++) begin
          acc = acc + scale(mode_q, 2'(j), 2'(c),
                            $signed({{(COEF_W - PIX_W){1'b0}}, x_q[r * 4 + c]}));
        end
        y_calc[r * 4 + j] = acc;
      end
    end
  end

  // Column pass: T = M * Y.
  always_comb begin
    logic signed [COEF_W-1:0] acc;
    t_calc = '{default: '0};
    for (int u = 0; u < 4; u++) begin
      for (int v = 0; v < 4; v++) begin
        acc = '0;
        for (int r = 0; r < 4; r++) begin
          acc = acc + scale(mode_q, 2'(u), 2'(r), y_q[r * 4 + v]);
        end
        t_calc[u * 4 + v] = acc;
      end
    end
  end

  // Raster address of tile pixel (r, c) = cnt[3:2], cnt[1:0].
  always_comb begin
    row_a     = ADDR_W'({ty_q, cnt_q[3:2]});
    col_a     = ADDR_W'({tx_q, cnt_q[1:0]});
    addr_calc = row_a * ADDR_W'(FRAME_W) + col_a;
  end

  // Control FSM next state; abort overrides every transition.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    tile_d    = tile_q;
    tx_d      = tx_q;
    ty_d      = ty_q;
    mode_d    = mode_q;
    cap_vld_d = 1'b0;
    cap_idx_d = cnt_q;
    case (state_q)
      StIdle: begin
        if (in_start && !in_abort) begin
          state_d = StLoad;
          mode_d  = in_mode;
          tile_d  = '0;
          tx_d    = '0;
          ty_d    = '0;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      StLoad: begin
        cap_vld_d = 1'b1;
        // Hold cnt at 15 so the address stays put during LAST.
        if (cnt_q == 4'd15) state_d = StLast;
        else                cnt_d   = cnt_q + 4'd1;
      end
      StLast: begin
        cnt_d   = '0;
        state_d = StRow;
      end
      StRow: state_d = StCol;
      StCol: state_d = StEmit;
      StEmit: begin
        if (in_coef_ready) begin
          if (idx_q == 4'd15) begin
            idx_d = '0;
            if (tile_q == TILE_W'(NT - 1)) begin
              state_d = StDone;
            end else begin
              state_d = StLoad;
              tile_d  = tile_q + TILE_W'(1);
              if (tx_q == TX_W'(TILES_X - 1)) begin
                tx_d = '0;
                ty_d = ty_q + TY_W'(1);
              end else begin
                tx_d = tx_q + TX_W'(1);
              end
            end
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (in_abort) begin
      state_d   = StIdle;
      cnt_d     = '0;
      idx_d     = '0;
      cap_vld_d = 1'b0;
    end
  end

  // Datapath next state: pixel capture and the two registered transform passes.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    t_d = t_q;
    if (cap_vld_q) x_d[cap_idx_q] = in_mem_data;
    if (state_q == StRow) y_d = y_calc;
    if (state_q == StCol) t_d = t_calc;
  end

  // State and datapath registers.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      idx_q     <= '0;
      tile_q    <= '0;
      tx_q      <= '0;
      ty_q      <= '0;
      mode_q    <= 1'b0;
      cap_vld_q <= 1'b0;
      cap_idx_q <= '0;
      for (int i = 0; i < 16; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
        t_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      tile_q    <= tile_d;
      tx_q      <= tx_d;
      ty_q      <= ty_d;
      mode_q    <= mode_d;
      cap_vld_q <= cap_vld_d;
      cap_idx_q <= cap_idx_d;
      x_q       <= x_d;
      y_q       <= y_d;
      t_q       <= t_d;
    end
  end

  // Outputs decoded from state; coefficient and address forced to 0 when not meaningful.
  always_comb begin
    out_coef_valid = (state_q == StEmit);
    out_coef       = out_coef_valid ? t_q[idx_q] : '0;
    out_coef_idx   = idx_q;
    out_tile_idx   = tile_q;
    out_busy       = (state_q != StIdle);
    out_done       = (state_q == StDone);
    out_mem_addr   = (state_q == StLoad || state_q == StLast) ? addr_calc : '0;
  end

endmodule
